// File: rtl/mem_ctrl.sv
// Byte-serial RAM port controller shared by instruction fetch and the MEM stage.
// Splits 1/2/4-byte accesses into single-byte RAM cycles and assembles little-endian read data.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_load_req,
  input  logic              mem_store_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_nbytes,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              owner_if_q, owner_if_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_a_q;

  logic [2:0]        n_mem;
  logic [2:0]        cnt_m1;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       rd_mask;

  // Unsupported sizes fall back to a full word.
  assign n_mem    = (mem_nbytes == 3'd1) ? 3'd1 : (mem_nbytes == 3'd2) ? 3'd2 : 3'd4;
  assign cnt_m1   = cnt_q - 3'd1;
  assign cur_addr = base_q + ADDR_W'(cnt_q);
  assign rd_mask  = (n_q == 3'd1) ? 32'h0000_00ff :
                    (n_q == 3'd2) ? 32'h0000_ffff : 32'hffff_ffff;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    owner_if_d = owner_if_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ram_a      = ram_a_q;
    ram_wr     = 1'b0;
    ram_dout   = 8'h00;
    if_done    = 1'b0;
    mem_done   = 1'b0;
    if_data    = 32'h0;
    mem_rdata  = 32'h0;

    case (state_q)
      IDLE: begin
        cnt_d   = 3'd0;
        rdata_d = 32'h0;
        if (mem_store_req) begin
          owner_if_d = 1'b0;
          base_d     = mem_addr;
          n_d        = n_mem;
          wdata_d    = mem_wdata;
          state_d    = WRITE;
        end else if (mem_load_req) begin
          owner_if_d = 1'b0;
          base_d     = mem_addr;
          n_d        = n_mem;
          state_d    = READ;
        end else if (if_req && !if_flush) begin
          owner_if_d = 1'b1;
          base_d     = if_addr;
          n_d        = 3'd4;
          state_d    = READ;
        end
      end

      READ: begin
        if (cnt_q < n_q) ram_a = cur_addr;
        // ram_din carries the byte addressed in the previous cycle
        if (cnt_q != 3'd0) rdata_d[{cnt_m1[1:0], 3'b000} +: 8] = ram_din;
        if (owner_if_q && if_flush) begin
          state_d = IDLE;
        end else if (cnt_q == n_q) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      WRITE: begin
        ram_a    = cur_addr;
        ram_wr   = 1'b1;
        ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == n_q - 3'd1) state_d = DONE;
        else cnt_d = cnt_q + 3'd1;
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        if (owner_if_q) begin
          if_done = !if_flush;
          if_data = rdata_q & rd_mask;
        end else begin
          mem_done  = 1'b1;
          mem_rdata = rdata_q & rd_mask;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd4;
      owner_if_q <= 1'b0;
      base_q     <= '0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      ram_a_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      owner_if_q <= owner_if_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ram_a_q    <= ram_a;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: directed scenarios plus randomized transactions checked
// against a byte-array reference memory and transaction-level latency rules.
module tb_mem_ctrl;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, mem_load_req, mem_store_req;
  logic [AW-1:0] if_addr, mem_addr, ram_a;
  logic [2:0]    mem_nbytes;
  logic [31:0]   mem_wdata, if_data, mem_rdata;
  logic          if_done, mem_done, ram_wr;
  logic [7:0]    ram_dout, ram_din;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_data(if_data), .if_done(if_done),
    .mem_load_req(mem_load_req), .mem_store_req(mem_store_req),
    .mem_addr(mem_addr), .mem_nbytes(mem_nbytes), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5a;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
    return w;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ram_rd(a + 32'(k));
    return w;
  endfunction

  function automatic int nsz(input logic [2:0] nb);
    return (nb == 3'd1) ? 1 : (nb == 3'd2) ? 2 : 4;
  endfunction

  // Synchronous RAM: one-cycle read latency, old data on same-cycle write.
  always @(posedge clk) begin
    ram_din <= ram_rd(ram_a);
    if (ram_wr) ram[ram_a] = ram_dout;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  // kind: 0 load, 1 store, 2 IF fetch. with_if holds if_req alongside a MEM access.
  // flush_at > 0 raises if_flush in that cycle after the grant (IF only).
  task automatic txn(input int kind, input logic [31:0] addr, input logic [2:0] nb,
                     input logic [31:0] wd, input bit with_if, input logic [31:0] iaddr,
                     input int flush_at);
    int          n, exp_lat, lat, ilat, bad_bus, other_done;
    bit          is_if, prim;
    logic [31:0] exp_data, got, exp_if;
    is_if    = (kind == 2);
    n        = is_if ? 4 : nsz(nb);
    exp_lat  = (kind == 1) ? n + 1 : n + 2;
    exp_data = (kind == 1) ? 32'h0 : ref_word(addr, n);
    lat = 0; bad_bus = 0; other_done = 0; got = 32'h0;

    @(negedge clk);
    mem_addr = addr; mem_nbytes = nb; mem_wdata = wd;
    if_addr  = is_if ? addr : iaddr;
    case (kind)
      0:       mem_load_req  = 1'b1;
      1:       mem_store_req = 1'b1;
      default: if_req        = 1'b1;
    endcase
    if (with_if) if_req = 1'b1;

    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (flush_at > 0 && c == flush_at) if_flush = 1'b1;
      if (flush_at > 0 && c == flush_at + 1) begin
        if_req = 1'b0; if_flush = 1'b0;
      end
      #1;
      if (c <= n && (flush_at <= 0 || c < flush_at)) begin
        if (ram_a !== addr + 32'(c - 1)) bad_bus++;
        if (kind == 1) begin
          if (ram_wr !== 1'b1 || ram_dout !== wd[8*(c-1) +: 8]) bad_bus++;
        end else if (ram_wr !== 1'b0) bad_bus++;
      end else if (ram_wr !== 1'b0) bad_bus++;
      prim = is_if ? if_done : mem_done;
      if ((is_if ? mem_done : if_done) === 1'b1) other_done++;
      if (prim === 1'b1) begin
        lat = c;
        got = is_if ? if_data : mem_rdata;
        if (is_if) if_req = 1'b0;
        mem_load_req = 1'b0; mem_store_req = 1'b0;
        break;
      end
      if (flush_at > 0 && c >= flush_at + 8) break;
    end

    if (flush_at > 0) begin
      chk("flush_no_done", 32'(lat), 32'd0);
    end else begin
      chk(is_if ? "if_latency" : (kind == 1 ? "st_latency" : "ld_latency"), 32'(lat), 32'(exp_lat));
      if (kind != 1) chk(is_if ? "if_data" : "ld_data", got, exp_data);
    end
    chk("bus_seq", 32'(bad_bus), 32'd0);
    chk("other_done", 32'(other_done), 32'd0);

    if (kind == 1) begin
      for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
      chk("st_bytes", ram_word(addr, n), ref_word(addr, n));
      chk("st_untouched", 32'(ram_rd(addr + 32'(n))), 32'(ref_rd(addr + 32'(n))));
    end

    if (with_if) begin
      exp_if = ref_word(iaddr, 4);
      ilat   = 0;
      got    = 32'h0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk); #1;
        if (if_done === 1'b1) begin
          ilat = c; got = if_data; if_req = 1'b0;
          break;
        end
      end
      chk("if_after_mem_lat", 32'(ilat), 32'd7);
      chk("if_after_mem_data", got, exp_if);
    end
    if_req = 1'b0;
  endtask

  initial begin
    int          kind, flush_at, lat;
    bit          with_if;
    logic [31:0] addr, wd, iaddr;
    logic [2:0]  nb;

    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; mem_load_req = 1'b0;
    mem_store_req = 1'b0; if_addr = '0; mem_addr = '0; mem_nbytes = 3'd4; mem_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    chk("rst_data", if_data | mem_rdata, 32'h0);
    rst = 1'b0;

    preload(32'h1000, 8'h11); preload(32'h1001, 8'h22);
    preload(32'h1002, 8'h33); preload(32'h1003, 8'h44);
    txn(0, 32'h1000, 3'd4, 32'h0, 1'b0, 32'h0, -1);
    chk("lw_word", ref_word(32'h1000, 4), 32'h4433_2211);
    txn(1, 32'h20, 3'd2, 32'hAABBCCDD, 1'b0, 32'h0, -1);
    txn(0, 32'h1002, 3'd1, 32'h0, 1'b1, 32'h1000, -1);
    txn(0, 32'hFFFF_FFFE, 3'd4, 32'h0, 1'b0, 32'h0, -1);
    txn(2, 32'h0, 3'd4, 32'h0, 1'b0, 32'h0, 3);
    txn(2, 32'h40, 3'd4, 32'h0, 1'b0, 32'h0, 6);
    txn(2, 32'h20, 3'd4, 32'h0, 1'b0, 32'h0, -1);

    // Reset in the second WRITE cycle of a word store; the request stays up.
    @(negedge clk);
    mem_store_req = 1'b1; mem_addr = 32'h300; mem_nbytes = 3'd4; mem_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_outs", {ram_a[23:0], ram_dout}, 32'h0);
    chk("midrst_flags", {29'd0, ram_wr, if_done, mem_done}, 32'd0);
    rst = 1'b0;
    lat = 0;
    for (int c = 4; c <= 30; c++) begin
      @(negedge clk); #1;
      if (mem_done === 1'b1) begin lat = c; mem_store_req = 1'b0; break; end
    end
    chk("midrst_restart_lat", 32'(lat), 32'd8);
    for (int k = 0; k < 4; k++) ref_mem[32'h300 + 32'(k)] = wd_byte(32'hCAFE_F00D, k);
    chk("midrst_bytes", ram_word(32'h300, 4), ref_word(32'h300, 4));

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else addr = 32'h100 + 32'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       nb = 3'd1;
        1:       nb = 3'd2;
        2:       nb = 3'd4;
        default: nb = 3'($urandom_range(0, 7));
      endcase
      wd       = $urandom;
      iaddr    = 32'h100 + 32'($urandom_range(0, 31));
      with_if  = (kind != 2) && ($urandom_range(0, 3) == 0);
      flush_at = (kind == 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
      txn(kind, addr, nb, wd, with_if, iaddr, flush_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [7:0] wd_byte(input logic [31:0] w, input int k);
    return w[8*k +: 8];
  endfunction

endmodule
